stage_if: RTL and testbench

Instruction-fetch stage, directly upstream of the decode stage. Fetches each 32-bit instruction as four byte reads over the shared byte-wide memory port, assembles it little-endian, and presents {pc, inst} to the IF/ID register. Accepts redirects from the branch-resolution path and holds its output while the pipeline is stalled.

---
 rtl/stage_if_if.sv | 11 +
 rtl/stage_if.sv | 151 +++++++++++++++
 tb/tb_stage_if.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_if_if.sv
// Byte-wide instruction memory port shared with the fetch arbiter.
// master = fetch stage (requester), slave = arbiter/memory side.
interface stage_if_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;

  modport master (output mem_req, output mem_addr, input mem_gnt, input mem_din);
  modport slave  (input mem_req, input mem_addr, output mem_gnt, output mem_din);
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: four byte reads per instruction, assembled little-endian.
// Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module stage_if #(
  parameter logic [31:0] START_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               br_valid,
  input  logic [31:0]        br_target,
  stage_if_if.master         mem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [2:0]  r_issue_cnt;
  logic [1:0]  r_recv_cnt;
  logic        r_pending;
  logic [23:0] r_buf;

  logic        w_issue;
  logic        w_done;
  logic        w_consume;
  logic        w_hit;
  logic [31:0] w_hit_inst;

  assign w_done    = (r_state == FETCH) && r_pending && (r_recv_cnt == 2'd3);
  assign w_consume = (r_state == HOLD) && if_valid && !stall_in;
  assign w_issue   = mem.mem_req && mem.mem_gnt;

  // Gating with reset keeps the request low even before the async clear settles.
  assign mem.mem_req  = reset && (r_state == FETCH) && (r_issue_cnt < 3'd4) && !w_hit;
  assign mem.mem_addr = mem.mem_req ? (r_pc + {29'd0, r_issue_cnt}) : 32'd0;

`ifdef ICACHE_EN
  localparam int ENTRIES = 1 << ICACHE_IDX_W;
  localparam int TAG_W   = 32 - ICACHE_IDX_W - 2;

  logic [31:0]             r_c_data [ENTRIES];
  logic [TAG_W-1:0]        r_c_tag  [ENTRIES];
  logic [ENTRIES-1:0]      r_c_vld;
  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;

  assign w_idx = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag = r_pc[31:ICACHE_IDX_W+2];

  // Lookup only in the first cycle of a fetch, before any byte has been requested.
  assign w_hit = (r_state == FETCH) && (r_issue_cnt == 3'd0) && (r_recv_cnt == 2'd0) &&
                 !r_pending && r_c_vld[w_idx] && (r_c_tag[w_idx] == w_tag);
  assign w_hit_inst = r_c_data[w_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_c_vld <= '0;
    else if (!br_valid && w_done)
      r_c_vld[w_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!br_valid && w_done) begin
      r_c_data[w_idx] <= {mem.mem_din, r_buf};
      r_c_tag[w_idx]  <= w_tag;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = 32'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= FETCH;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (br_valid)
      w_state_nxt = FETCH;
    else begin
      case (r_state)
        FETCH:   if (w_done || w_hit) w_state_nxt = HOLD;
        HOLD:    if (w_consume)       w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // Control and presented outputs; redirect overrides every other update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= START_PC;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 2'd0;
      r_pending   <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_inst     <= 32'd0;
    end else if (br_valid) begin
      r_pc        <= br_target & ~32'd3;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 2'd0;
      r_pending   <= 1'b0;
      if_valid    <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue)
        r_issue_cnt <= r_issue_cnt + 3'd1;
      if (r_pending)
        r_recv_cnt <= r_recv_cnt + 2'd1;
      if (w_done) begin
        if_valid <= 1'b1;
        if_pc    <= r_pc;
        if_inst  <= {mem.mem_din, r_buf};
      end else if (w_hit) begin
        if_valid <= 1'b1;
        if_pc    <= r_pc;
        if_inst  <= w_hit_inst;
      end
      if (w_consume) begin
        r_pc        <= r_pc + 32'd4;
        if_valid    <= 1'b0;
        r_issue_cnt <= 3'd0;
        r_recv_cnt  <= 2'd0;
        r_pending   <= 1'b0;
      end
    end
  end

  // Bytes 0..2 are staged here; byte 3 goes straight into if_inst.
  always_ff @(posedge clk) begin
    if (r_pending) begin
      case (r_recv_cnt)
        2'd0:    r_buf[7:0]   <= mem.mem_din;
        2'd1:    r_buf[15:8]  <= mem.mem_din;
        2'd2:    r_buf[23:16] <= mem.mem_din;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed fetch/stall/redirect/wrap scenarios, then randomized run vs a PC-level model.
module tb_stage_if;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  stage_if_if mif ();

  stage_if #(.START_PC(32'h0), .ICACHE_IDX_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall_in  (stall_in),
    .br_valid  (br_valid),
    .br_target (br_target),
    .mem       (mif),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  // Memory answers a granted request on the next cycle; otherwise the bus carries junk.
  always @(posedge clk) begin
    if (mif.mem_req && mif.mem_gnt)
      mif.mem_din <= mem[mif.mem_addr[9:0]];
    else
      mif.mem_din <= 8'($urandom);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic setw(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] ak;
    for (int k = 0; k < 4; k++) begin
      ak = a + 32'(k);
      mem[ak[9:0]] = w[8*k +: 8];
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  logic [31:0] mpc;
  int          g;
  int          idle;
  int          n_pres;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    setw(32'h0,   32'h00A00513);
    setw(32'h4,   32'h00100593);
    setw(32'h104, 32'hDEADBEEF);
    mif.mem_gnt = 1'b1;

    // Reset state
    repeat (2) cyc;
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_addr", mif.mem_addr, 0);

    // Basic fetch from START_PC with continuous grant
    reset = 1'b1;
    #1;
    chk("t1_req_c1", mif.mem_req, 1);
    chk("t1_addr_c1", mif.mem_addr, 0);
    for (int k = 1; k < 4; k++) begin
      cyc;
      chk("t1_req", mif.mem_req, 1);
      chk("t1_addr", mif.mem_addr, 32'(k));
    end
    cyc;
    chk("t1_req_c5", mif.mem_req, 0);
    chk("t1_vld_c5", if_valid, 0);
    cyc;
    chk("t1_vld_c6", if_valid, 1);
    chk("t1_inst", if_inst, 32'h00A00513);
    chk("t1_pc", if_pc, 32'h0);

    // Stall holds the presented instruction
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("t2_vld", if_valid, 1);
      chk("t2_inst", if_inst, 32'h00A00513);
      chk("t2_pc", if_pc, 32'h0);
      chk("t2_req", mif.mem_req, 0);
    end
    stall_in = 1'b0;
    cyc;
    chk("t2_next_req", mif.mem_req, 1);
    chk("t2_next_addr", mif.mem_addr, 32'h4);

    // Grant gap on the second byte
    cyc;
    chk("t3_addr_b", mif.mem_addr, 32'h5);
    mif.mem_gnt = 1'b0;
    cyc;
    chk("t3_addr_c", mif.mem_addr, 32'h5);
    cyc;
    chk("t3_addr_d", mif.mem_addr, 32'h5);
    mif.mem_gnt = 1'b1;
    cyc;
    chk("t3_addr_e", mif.mem_addr, 32'h6);
    cyc;
    chk("t3_addr_f", mif.mem_addr, 32'h7);
    cyc;
    chk("t3_req_g", mif.mem_req, 0);
    chk("t3_vld_g", if_valid, 0);
    cyc;
    chk("t3_vld_h", if_valid, 1);
    chk("t3_pc", if_pc, 32'h4);
    chk("t3_inst", if_inst, 32'h00100593);

    // Redirect with stall in the same cycle as if_valid
    br_valid  = 1'b1;
    br_target = 32'h22;
    stall_in  = 1'b1;
    cyc;
    br_valid = 1'b0;
    stall_in = 1'b0;
    chk("t5_vld", if_valid, 0);
    chk("t5_req", mif.mem_req, 1);
    chk("t5_addr", mif.mem_addr, 32'h20);

    // Redirect after byte 1 granted; its returning byte must be dropped
    cyc;
    chk("t4_addr1", mif.mem_addr, 32'h21);
    cyc;
    chk("t4_addr2", mif.mem_addr, 32'h22);
    br_valid  = 1'b1;
    br_target = 32'h107;
    cyc;
    br_valid = 1'b0;
    chk("t4_addr_redir", mif.mem_addr, 32'h104);
    chk("t4_vld0", if_valid, 0);
    repeat (4) cyc;
    chk("t4_vld_early", if_valid, 0);
    cyc;
    chk("t4_vld", if_valid, 1);
    chk("t4_pc", if_pc, 32'h104);
    chk("t4_inst", if_inst, 32'hDEADBEEF);

    // PC wrap at the top of the address space
    reset = 1'b0;
    cyc;
    reset     = 1'b1;
    br_valid  = 1'b1;
    br_target = 32'hFFFF_FFFF;
    cyc;
    br_valid = 1'b0;
    chk("wrap_addr", mif.mem_addr, 32'hFFFF_FFFC);
    repeat (5) cyc;
    chk("wrap_vld", if_valid, 1);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", if_inst, word(32'hFFFF_FFFC));
    cyc;
    chk("wrap_req", mif.mem_req, 1);
    chk("wrap_next_addr", mif.mem_addr, 32'h0);

    // Asynchronous reset mid-fetch
    reset = 1'b0;
    #1;
    chk("arst_req", mif.mem_req, 0);
    chk("arst_vld", if_valid, 0);
    cyc;
    reset = 1'b1;
    #1;

    // Randomized run against a PC-level model
    mpc = 32'h0;
    g = 0;
    idle = 0;
    n_pres = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_valid) begin
        chk("rnd_req_hold", mif.mem_req, 0);
        chk("rnd_pc", if_pc, mpc);
        chk("rnd_inst", if_inst, word(mpc));
        n_pres++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 150) begin
          chk("rnd_live", 32'(idle), 0);
          idle = 0;
        end
      end
      if (mif.mem_req)
        chk("rnd_addr", mif.mem_addr, mpc + 32'(g));
      mif.mem_gnt = ($urandom_range(0, 3) != 0);
      stall_in    = ($urandom_range(0, 2) == 0);
      br_valid    = ($urandom_range(0, 24) == 0);
      br_target   = $urandom;
      if (br_valid) begin
        mpc = br_target & ~32'd3;
        g = 0;
      end else if (if_valid && !stall_in) begin
        mpc = mpc + 32'd4;
        g = 0;
      end else if (mif.mem_req && mif.mem_gnt) begin
        g++;
      end
      cyc;
    end
    chk("rnd_presented", 32'(n_pres > 20), 1);

`ifdef ICACHE_EN
    // Cache: refetch of pc 0 hits without memory traffic; reset invalidates
    mif.mem_gnt = 1'b1;
    stall_in = 1'b0;
    br_valid = 1'b0;
    reset = 1'b0;
    cyc;
    reset = 1'b1;
    #1;
    chk("ic_miss0_addr", mif.mem_addr, 32'h0);
    repeat (5) cyc;
    chk("ic_vld0", if_valid, 1);
    cyc;
    chk("ic_addr4", mif.mem_addr, 32'h4);
    repeat (5) cyc;
    chk("ic_vld4", if_valid, 1);
    chk("ic_pc4", if_pc, 32'h4);
    br_valid = 1'b1;
    br_target = 32'h0;
    cyc;
    br_valid = 1'b0;
    chk("ic_hit_req", mif.mem_req, 0);
    cyc;
    chk("ic_hit_vld", if_valid, 1);
    chk("ic_hit_pc", if_pc, 32'h0);
    chk("ic_hit_inst", if_inst, 32'h00A00513);
    reset = 1'b0;
    cyc;
    reset = 1'b1;
    #1;
    chk("ic_rst_miss_req", mif.mem_req, 1);
    chk("ic_rst_miss_addr", mif.mem_addr, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
